// File: rtl/predecode_register_if.sv
// rtl/predecode_register_if.sv - Bus bundle between the fetch/pin side and predecode_register
interface predecode_register_if;
  logic       rdy;
  logic [7:0] data_in;
  logic       fetch;
  logic       i_flag;
  logic       irq_n;
  logic       nmi_n;
  logic [7:0] instruction;
  logic [1:0] int_type;
  logic       instr_valid;
  logic       nmi_pending;

  modport master (
    output rdy, data_in, fetch, i_flag, irq_n, nmi_n,
    input  instruction, int_type, instr_valid, nmi_pending
  );

  modport slave (
    input  rdy, data_in, fetch, i_flag, irq_n, nmi_n,
    output instruction, int_type, instr_valid, nmi_pending
  );
endinterface

// File: rtl/predecode_register.sv
// rtl/predecode_register.sv - Opcode holding register with IRQ/NMI/reset BRK injection
module predecode_register #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter logic [7:0]  BRK_OPCODE   = 8'h00,
  parameter logic [7:0]  RESET_OPCODE = 8'hEA
) (
  input logic                   clk,
  input logic                   res,
  predecode_register_if.slave   bus
);
  localparam logic [1:0] INT_NONE  = 2'b00;
  localparam logic [1:0] INT_IRQ   = 2'b01;
  localparam logic [1:0] INT_NMI   = 2'b10;
  localparam logic [1:0] INT_RESET = 2'b11;

  logic [SYNC_STAGES-1:0] r_irq_sync;
  logic [SYNC_STAGES-1:0] r_nmi_sync;
  logic                   r_nmi_prev;
  logic                   r_nmi_pending;
  logic                   r_reset_pending;
  logic                   r_instr_valid;
  logic [7:0]             r_instruction;
  logic [1:0]             r_int_type;

  logic       w_irq_s;
  logic       w_nmi_s;
  logic       w_nmi_fall;
  logic       w_fetch_go;
  logic       w_inject_nmi;
  logic [7:0] w_next_instruction;
  logic [1:0] w_next_int_type;

  assign w_irq_s    = r_irq_sync[SYNC_STAGES-1];
  assign w_nmi_s    = r_nmi_sync[SYNC_STAGES-1];
  assign w_nmi_fall = r_nmi_prev & ~w_nmi_s;
  assign w_fetch_go = bus.rdy & bus.fetch;

  // Synchronisers and edge history run every cycle so rdy never masks an NMI edge.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_irq_sync <= '1;
      r_nmi_sync <= '1;
      r_nmi_prev <= 1'b1;
    end else begin
      r_irq_sync <= {r_irq_sync[SYNC_STAGES-2:0], bus.irq_n};
      r_nmi_sync <= {r_nmi_sync[SYNC_STAGES-2:0], bus.nmi_n};
      r_nmi_prev <= w_nmi_s;
    end
  end

  always_comb begin
    w_next_instruction = bus.data_in;
    w_next_int_type    = INT_NONE;
    w_inject_nmi       = 1'b0;
    if (r_reset_pending) begin
      w_next_instruction = BRK_OPCODE;
      w_next_int_type    = INT_RESET;
    end else if (r_nmi_pending) begin
      w_next_instruction = BRK_OPCODE;
      w_next_int_type    = INT_NMI;
      w_inject_nmi       = 1'b1;
    end else if (!w_irq_s && !bus.i_flag) begin
      w_next_instruction = BRK_OPCODE;
      w_next_int_type    = INT_IRQ;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_instruction   <= RESET_OPCODE;
      r_int_type      <= INT_NONE;
      r_instr_valid   <= 1'b0;
      r_reset_pending <= 1'b1;
      r_nmi_pending   <= 1'b0;
    end else begin
      if (w_fetch_go) begin
        r_instruction   <= w_next_instruction;
        r_int_type      <= w_next_int_type;
        r_instr_valid   <= 1'b1;
        r_reset_pending <= 1'b0;
      end
      // A fresh edge in the injection cycle keeps the request alive.
      if (w_nmi_fall) begin
        r_nmi_pending <= 1'b1;
      end else if (w_fetch_go && w_inject_nmi) begin
        r_nmi_pending <= 1'b0;
      end
    end
  end

  assign bus.instruction = r_instruction;
  assign bus.int_type    = r_int_type;
  assign bus.instr_valid = r_instr_valid;
  assign bus.nmi_pending = r_nmi_pending;
endmodule

// File: tb/tb_predecode_register.sv
// tb/tb_predecode_register.sv - Scoreboard bench for predecode_register
module tb_predecode_register;
  logic clk;
  logic res;
  int   n_cmp;
  int   n_bad;

  typedef struct {
    logic [7:0] instr;
    logic [1:0] itype;
    logic       pend;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  predecode_register_if bus_if ();

  predecode_register #(
    .SYNC_STAGES (2),
    .BRK_OPCODE  (8'h00),
    .RESET_OPCODE(8'hEA)
  ) dut (
    .clk(clk),
    .res(res),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted fetch must be matched by the next queued expectation.
  always @(posedge clk) begin
    if (res && bus_if.rdy && bus_if.fetch) begin
      #1;
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow: fetch accepted with no expectation queued");
      end else begin
        mon_e = sb_q.pop_front();
        check({mon_e.name, ".instruction"}, bus_if.instruction, mon_e.instr);
        check({mon_e.name, ".int_type"}, {6'd0, bus_if.int_type}, {6'd0, mon_e.itype});
        check({mon_e.name, ".instr_valid"}, {7'd0, bus_if.instr_valid}, 8'd1);
        check({mon_e.name, ".nmi_pending"}, {7'd0, bus_if.nmi_pending}, {7'd0, mon_e.pend});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_fetch(input string name, input logic [7:0] d, input logic [7:0] ei,
                          input logic [1:0] et, input logic ep);
    exp_t e;
    e.instr = ei;
    e.itype = et;
    e.pend  = ep;
    e.name  = name;
    sb_q.push_back(e);
    bus_if.data_in = d;
    bus_if.rdy     = 1'b1;
    bus_if.fetch   = 1'b1;
    @(negedge clk);
    bus_if.fetch   = 1'b0;
  endtask

  task automatic check_outs(input string name, input logic [7:0] ei, input logic [1:0] et,
                            input logic ev, input logic ep);
    check({name, ".instruction"}, bus_if.instruction, ei);
    check({name, ".int_type"}, {6'd0, bus_if.int_type}, {6'd0, et});
    check({name, ".instr_valid"}, {7'd0, bus_if.instr_valid}, {7'd0, ev});
    check({name, ".nmi_pending"}, {7'd0, bus_if.nmi_pending}, {7'd0, ep});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    res            = 1'b0;
    bus_if.rdy     = 1'b1;
    bus_if.data_in = 8'h00;
    bus_if.fetch   = 1'b0;
    bus_if.i_flag  = 1'b1;
    bus_if.irq_n   = 1'b1;
    bus_if.nmi_n   = 1'b1;
    idle(3);
    check_outs("reset", 8'hEA, 2'b00, 1'b0, 1'b0);
    res = 1'b1;
    idle(2);
    check_outs("post_release", 8'hEA, 2'b00, 1'b0, 1'b0);

    do_fetch("reset_brk", 8'hA9, 8'h00, 2'b11, 1'b0);
    do_fetch("first_opcode", 8'hA9, 8'hA9, 2'b00, 1'b0);
    bus_if.data_in = 8'h5A;
    idle(2);
    check_outs("non_fetch_hold", 8'hA9, 2'b00, 1'b1, 1'b0);

    bus_if.nmi_n = 1'b0;
    idle(3);
    check_outs("nmi_latched", 8'hA9, 2'b00, 1'b1, 1'b1);
    idle(1);
    do_fetch("nmi_brk", 8'h06, 8'h00, 2'b10, 1'b0);
    do_fetch("nmi_held_low", 8'h06, 8'h06, 2'b00, 1'b0);
    bus_if.nmi_n = 1'b1;

    bus_if.irq_n = 1'b0;
    idle(3);
    do_fetch("irq_masked", 8'h55, 8'h55, 2'b00, 1'b0);
    bus_if.i_flag = 1'b0;
    do_fetch("irq_taken", 8'h55, 8'h00, 2'b01, 1'b0);

    bus_if.nmi_n = 1'b0;
    idle(4);
    do_fetch("nmi_over_irq", 8'h77, 8'h00, 2'b10, 1'b0);
    do_fetch("irq_after_nmi", 8'h77, 8'h00, 2'b01, 1'b0);
    bus_if.irq_n = 1'b1;
    bus_if.nmi_n = 1'b1;
    idle(3);
    do_fetch("irq_released_lost", 8'h12, 8'h12, 2'b00, 1'b0);

    bus_if.data_in = 8'h33;
    bus_if.rdy     = 1'b0;
    bus_if.fetch   = 1'b1;
    bus_if.nmi_n   = 1'b0;
    idle(4);
    check_outs("rdy_low_freeze", 8'h12, 2'b00, 1'b1, 1'b1);
    bus_if.fetch = 1'b0;
    do_fetch("rdy_resume_nmi", 8'h33, 8'h00, 2'b10, 1'b0);

    bus_if.nmi_n = 1'b1;
    idle(3);
    bus_if.nmi_n = 1'b0;
    idle(3);
    bus_if.nmi_n = 1'b1;
    idle(3);
    check_outs("nmi_armed", 8'h00, 2'b10, 1'b1, 1'b1);
    bus_if.nmi_n = 1'b0;
    idle(2);
    do_fetch("set_wins", 8'h44, 8'h00, 2'b10, 1'b1);
    do_fetch("set_wins_second", 8'h44, 8'h00, 2'b10, 1'b0);

    bus_if.nmi_n = 1'b1;
    idle(3);
    bus_if.nmi_n = 1'b0;
    idle(3);
    check_outs("pre_abort", 8'h00, 2'b10, 1'b1, 1'b1);
    #2;
    res = 1'b0;
    #1;
    check_outs("async_abort", 8'hEA, 2'b00, 1'b0, 1'b0);
    bus_if.nmi_n = 1'b1;
    @(negedge clk);
    res = 1'b1;
    idle(3);
    check_outs("abort_release", 8'hEA, 2'b00, 1'b0, 1'b0);
    do_fetch("reset_brk_again", 8'hC3, 8'h00, 2'b11, 1'b0);
    do_fetch("opcode_again", 8'hC3, 8'hC3, 2'b00, 1'b0);

    idle(2);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_leftover: got %0d queued, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/predecode_register.md
Name: predecode_register

Overview:
Opcode holding register and interrupt injector placed directly upstream of instruction_decode; its `instruction` output drives the decoder's `instruction` input.
- Samples the data bus on opcode-fetch cycles and holds the fetched byte stable for the decoder.
- Synchronises the external IRQ/NMI pins and detects NMI edges.
- On reset exit, a pending NMI, or an enabled IRQ, substitutes BRK (0x00) for the fetched byte and reports the interrupt source, so the decoder runs one shared BRK/vector sequence.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the irq_n/nmi_n synchronisers (minimum 2)
BRK_OPCODE, 8'h00, byte injected on an interrupt
RESET_OPCODE, 8'hEA, value of `instruction` while in reset (NOP)

Ports:
clk  in  1  system clock; all state changes on posedge
res  in  1  asynchronous, active-low reset
rdy  in  1  1 = advance; 0 = freeze all state except synchronisers and NMI edge capture
data_in  in  8  external data bus
fetch  in  1  1 = current cycle is an opcode fetch (decoder in S_OPCODE_READ)
i_flag  in  1  processor status I bit; 1 = IRQ masked
irq_n  in  1  external IRQ pin, active-low, level sensitive, asynchronous to clk
nmi_n  in  1  external NMI pin, active-low, falling-edge sensitive, asynchronous
instruction  out  8  held opcode or injected BRK, to the decoder
int_type  out  2  00 none / software BRK, 01 IRQ, 10 NMI, 11 RESET; valid with `instruction`
instr_valid  out  1  1 once at least one fetch has completed since reset
nmi_pending  out  1  NMI latched, not yet injected (debug/visibility)

Behaviour:
Reset (`res`=0, asynchronous):
- instruction = RESET_OPCODE, int_type = 00, instr_valid = 0, nmi_pending = 0.
- Internal reset_pending = 1; all synchroniser flops = 1 (pins inactive).
- Reset asserted mid-operation aborts everything and discards any pending NMI.

Synchronisers:
- irq_s and nmi_s are SYNC_STAGES-deep copies of irq_n and nmi_n.
- They clock every cycle, regardless of rdy.

NMI edge detect:
- nmi_fall = previous nmi_s AND NOT nmi_s.
- nmi_fall sets nmi_pending even when rdy = 0.
- nmi_pending clears only on the cycle an NMI is injected.
- If a new nmi_fall occurs in that same cycle, set wins and nmi_pending stays 1.
- Holding nmi_n low does not retrigger; a new falling edge is required.

Fetch cycle (posedge with rdy = 1 and fetch = 1), in priority order:
1. reset_pending = 1: instruction <= BRK_OPCODE, int_type <= 11, reset_pending <= 0.
2. nmi_pending = 1: instruction <= BRK_OPCODE, int_type <= 10, nmi_pending cleared (subject to the set-wins rule).
3. irq_s = 0 and i_flag = 0: instruction <= BRK_OPCODE, int_type <= 01. Level sensitive, nothing latched; an IRQ released before a fetch is lost.
4. Otherwise: instruction <= data_in, int_type <= 00.

On every fetch cycle:
- instr_valid <= 1.
- A lower-priority request that loses remains pending (NMI) or is re-evaluated at the next fetch (IRQ).

Non-fetch cycles and rdy = 0:
- instruction, int_type and instr_valid hold.
- fetch with rdy = 0 is ignored.

Latency and timing:
- Output updates one clock after the sampled fetch edge; the decoder sees the new value in its next state.
- An external pin change needs SYNC_STAGES cycles to reach irq_s/nmi_s, plus 1 cycle for nmi_pending.
- i_flag is sampled in the fetch cycle itself; a CLI/SEI completing in that cycle takes effect immediately.

Test Plan:
- Release res, hold data_in = 8'hA9, pulse fetch -> instruction = 00, int_type = 11; next fetch -> instruction = A9, int_type = 00, instr_valid = 1.
- Falling edge on nmi_n, then fetch 4 cycles later with data_in = 8'h06 -> instruction = 00, int_type = 10, nmi_pending 1 -> 0; keep nmi_n low and fetch again -> instruction = 06, int_type = 00.
- irq_n low with i_flag = 1 and fetch -> instruction = data_in, int_type = 00; drop i_flag to 0 and fetch -> instruction = 00, int_type = 01.
- irq_n low, i_flag = 0 and NMI edge pending on the same fetch -> int_type = 10; following fetch with irq still low -> int_type = 01.
- rdy = 0 while fetch = 1 and an NMI edge occurs -> instruction unchanged, nmi_pending = 1; raise rdy and fetch -> int_type = 10.
- Assert res asynchronously mid-cycle with nmi_pending = 1 -> outputs go immediately to EA / 00 / 0, nmi_pending = 0; first fetch after release -> int_type = 11.
